multicycle_datapath: RTL and testbench

Multicycle successor to the single-cycle RV32I datapath. One register file, one ALU and an immediate generator are shared across a 5-state FSM (fetch/decode/execute/memory/writeback). Instruction and data memories are external and reached through req/ack handshakes, so wait states are tolerated. Adds conditional branch (BEQ) support. Takes the same control inputs from the existing combinational controller.

---
 rtl/multicycle_datapath.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I datapath: one register file, ALU and immediate generator shared by a
// fetch/decode/execute/memory/writeback FSM, with req/ack ports to external memories.
module multicycle_datapath #(
    parameter int PC_W       = 8,
    parameter int INS_W      = 32,
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5,
    parameter int DM_ADDRESS = 9,
    parameter int ALU_CC_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic                  mem2reg,
    input  logic                  alu_src,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic                  branch,
    input  logic [ALU_CC_W-1:0]   alu_cc,
    output logic [6:0]            opcode,
    output logic [6:0]            funct7,
    output logic [2:0]            funct3,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [INS_W-1:0]      imem_rdata,
    input  logic                  imem_ack,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DM_ADDRESS-1:0] dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic [DATA_W-1:0]     alu_result,
    output logic                  instr_done
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t                state_r;
    logic [PC_W-1:0]       pc_r;
    logic [INS_W-1:0]      ir_r;
    logic [DATA_W-1:0]     a_r, b_r, alu_out_r, mdr_r;
    logic [DATA_W-1:0]     rf_r [0:(1<<RF_ADDRESS)-1];
    logic                  reg_write_r, mem2reg_r, alu_src_r, mem_write_r, mem_read_r, branch_r;
    logic [ALU_CC_W-1:0]   alu_cc_r;
    logic                  taken_r;
    logic                  imem_req_r, dmem_req_r, dmem_we_r, instr_done_r;

    logic [DATA_W-1:0]     imm_s, alu_b_s, alu_res_s, beq_diff_s;

    function automatic logic [DATA_W-1:0] imm_gen(input logic [INS_W-1:0] ir);
        case (ir[6:0])
            7'b0000011, 7'b0010011: imm_gen = {{(DATA_W-12){ir[31]}}, ir[31:20]};
            7'b0100011:             imm_gen = {{(DATA_W-12){ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011:             imm_gen = {{(DATA_W-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:                imm_gen = {DATA_W{1'b0}};
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] alu_op(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [ALU_CC_W-1:0] cc);
        case (cc)
            4'b0000: alu_op = a & b;
            4'b0001: alu_op = a | b;
            4'b0010: alu_op = a + b;
            4'b0110: alu_op = a - b;
            4'b0111: alu_op = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: alu_op = ~(a | b);
            default: alu_op = {DATA_W{1'b0}};
        endcase
    endfunction

    // Immediate, ALU operand mux and branch compare, all from registered state.
    always_comb begin
        imm_s      = imm_gen(ir_r);
        alu_b_s    = alu_src_r ? imm_s : b_r;
        alu_res_s  = alu_op(a_r, alu_b_s, alu_cc_r);
        beq_diff_s = a_r - b_r;
    end

    assign opcode     = ir_r[6:0];
    assign funct3     = ir_r[14:12];
    assign funct7     = ir_r[31:25];
    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = alu_out_r[DM_ADDRESS-1:0];
    assign dmem_wdata = b_r;
    assign alu_result = alu_out_r;
    assign instr_done = instr_done_r;

    // Instruction sequencer; request/done outputs are set on entry to the state that owns them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_FETCH;
            pc_r         <= {PC_W{1'b0}};
            ir_r         <= {INS_W{1'b0}};
            a_r          <= {DATA_W{1'b0}};
            b_r          <= {DATA_W{1'b0}};
            alu_out_r    <= {DATA_W{1'b0}};
            mdr_r        <= {DATA_W{1'b0}};
            for (int i = 0; i < (1<<RF_ADDRESS); i++) rf_r[i] <= {DATA_W{1'b0}};
            reg_write_r  <= 1'b0;
            mem2reg_r    <= 1'b0;
            alu_src_r    <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            branch_r     <= 1'b0;
            alu_cc_r     <= {ALU_CC_W{1'b0}};
            taken_r      <= 1'b0;
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            instr_done_r <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (imem_req_r && imem_ack) begin
                        ir_r       <= imem_rdata;
                        imem_req_r <= 1'b0;
                        state_r    <= S_DECODE;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                S_DECODE: begin
                    a_r         <= rf_r[ir_r[19:15]];
                    b_r         <= rf_r[ir_r[24:20]];
                    reg_write_r <= reg_write;
                    mem2reg_r   <= mem2reg;
                    alu_src_r   <= alu_src;
                    mem_write_r <= mem_write;
                    mem_read_r  <= mem_read;
                    branch_r    <= branch;
                    alu_cc_r    <= alu_cc;
                    taken_r     <= 1'b0;
                    state_r     <= S_EXEC;
                end
                S_EXEC: begin
                    alu_out_r <= alu_res_s;
                    taken_r   <= branch_r && (beq_diff_s == {DATA_W{1'b0}});
                    if (mem_read_r || mem_write_r) begin
                        dmem_req_r <= 1'b1;
                        dmem_we_r  <= mem_write_r;
                        state_r    <= S_MEM;
                    end else begin
                        instr_done_r <= 1'b1;
                        state_r      <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_req_r && dmem_ack) begin
                        if (mem_read_r) mdr_r <= dmem_rdata;
                        dmem_req_r   <= 1'b0;
                        dmem_we_r    <= 1'b0;
                        instr_done_r <= 1'b1;
                        state_r      <= S_WB;
                    end
                end
                S_WB: begin
                    // x0 is never written, so reading it always yields zero.
                    if (reg_write_r && (ir_r[11:7] != 5'd0))
                        rf_r[ir_r[11:7]] <= mem2reg_r ? mdr_r : alu_out_r;
                    pc_r         <= taken_r ? (pc_r + imm_s[PC_W-1:0])
                                            : (pc_r + {{(PC_W-3){1'b0}}, 3'd4});
                    instr_done_r <= 1'b0;
                    imem_req_r   <= 1'b1;
                    state_r      <= S_FETCH;
                end
                default: begin
                    state_r      <= S_FETCH;
                    imem_req_r   <= 1'b0;
                    dmem_req_r   <= 1'b0;
                    dmem_we_r    <= 1'b0;
                    instr_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Random-program bench: ISA-level reference model, random-latency memories with stray acks.
module tb_multicycle_datapath;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_SLT = 4, K_NOR = 5,
                   K_ADDI = 6, K_ANDI = 7, K_ORI = 8, K_SLTI = 9, K_LW = 10, K_SW = 11, K_BEQ = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write, mem2reg, alu_src, mem_write, mem_read, branch;
    logic [3:0]  alu_cc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [8:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata, alu_result;
    logic        instr_done;

    multicycle_datapath dut (
        .clk(clk), .reset(reset),
        .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
        .mem_write(mem_write), .mem_read(mem_read), .branch(branch), .alu_cc(alu_cc),
        .opcode(opcode), .funct7(funct7), .funct3(funct3),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .alu_result(alu_result), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // External combinational controller (R-type funct3=100 is mapped to NOR).
    always_comb begin
        reg_write = 1'b0; mem2reg = 1'b0; alu_src = 1'b0;
        mem_write = 1'b0; mem_read = 1'b0; branch = 1'b0; alu_cc = 4'b0010;
        case (opcode)
            7'b0110011: begin
                reg_write = 1'b1;
                case (funct3)
                    3'b000:  alu_cc = funct7[5] ? 4'b0110 : 4'b0010;
                    3'b111:  alu_cc = 4'b0000;
                    3'b110:  alu_cc = 4'b0001;
                    3'b010:  alu_cc = 4'b0111;
                    3'b100:  alu_cc = 4'b1100;
                    default: alu_cc = 4'b0010;
                endcase
            end
            7'b0010011: begin
                reg_write = 1'b1; alu_src = 1'b1;
                case (funct3)
                    3'b111:  alu_cc = 4'b0000;
                    3'b110:  alu_cc = 4'b0001;
                    3'b010:  alu_cc = 4'b0111;
                    default: alu_cc = 4'b0010;
                endcase
            end
            7'b0000011: begin reg_write = 1'b1; mem2reg = 1'b1; alu_src = 1'b1; mem_read = 1'b1; end
            7'b0100011: begin alu_src = 1'b1; mem_write = 1'b1; end
            7'b1100011: begin branch = 1'b1; alu_cc = 4'b0110; end
            default: ;
        endcase
    end

    logic [31:0] prog [64];
    int          p_kind [64], p_rd [64], p_rs1 [64], p_rs2 [64], p_imm [64];
    logic [31:0] m_reg [32];
    logic [7:0]  m_pc;
    logic [31:0] ref_mem [512];
    logic [31:0] ext_mem [512];

    int  n_checks = 0, n_errors = 0;
    int  cyc = 0, last_done = 0, n_instr = 0;
    int  i_wait, i_used, d_wait, d_used, d_req_cycles, force_wait;
    bit  i_pend, d_pend, have_last, hold_st;
    logic [8:0]  d_addr_seen;
    logic        d_we_seen;
    logic [31:0] d_wdata_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input int idx, input int kind, input int rd, input int rs1,
                       input int rs2, input int imm);
        logic [11:0] i12;
        logic [12:0] b13;
        logic [31:0] w;
        logic [4:0]  d, s1, s2;
        i12 = imm[11:0]; b13 = imm[12:0];
        d = rd[4:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
        case (kind)
            K_ADD:  w = {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
            K_SUB:  w = {7'b0100000, s2, s1, 3'b000, d, 7'b0110011};
            K_AND:  w = {7'b0000000, s2, s1, 3'b111, d, 7'b0110011};
            K_OR:   w = {7'b0000000, s2, s1, 3'b110, d, 7'b0110011};
            K_SLT:  w = {7'b0000000, s2, s1, 3'b010, d, 7'b0110011};
            K_NOR:  w = {7'b0000000, s2, s1, 3'b100, d, 7'b0110011};
            K_ADDI: w = {i12, s1, 3'b000, d, 7'b0010011};
            K_ANDI: w = {i12, s1, 3'b111, d, 7'b0010011};
            K_ORI:  w = {i12, s1, 3'b110, d, 7'b0010011};
            K_SLTI: w = {i12, s1, 3'b010, d, 7'b0010011};
            K_LW:   w = {i12, s1, 3'b010, d, 7'b0000011};
            K_SW:   w = {i12[11:5], s2, s1, 3'b010, i12[4:0], 7'b0100011};
            K_BEQ:  w = {b13[12], b13[10:5], s2, s1, 3'b000, b13[4:1], b13[11], 7'b1100011};
            default: w = 32'd0;
        endcase
        prog[idx] = w; p_kind[idx] = kind; p_rd[idx] = rd;
        p_rs1[idx] = rs1; p_rs2[idx] = rs2; p_imm[idx] = imm;
    endtask

    task automatic put_random(input int idx);
        int k, rs1, rs2, imm;
        k   = int'($urandom_range(0, 12));
        rs1 = int'($urandom_range(0, 7));
        rs2 = ($urandom_range(0, 1) == 0) ? rs1 : int'($urandom_range(0, 7));
        imm = (k == K_BEQ) ? 4 * int'($urandom_range(2, 8)) : int'($urandom_range(0, 4095)) - 2048;
        put(idx, k, int'($urandom_range(0, 7)), rs1, rs2, imm);
    endtask

    // Retire one instruction in the reference model and compare against what the DUT did.
    task automatic model_step();
        int idx, k, lat;
        logic [31:0] a, b, iv, res;
        logic [8:0]  addr;
        bit taken, mem_op;
        idx = int'(m_pc[7:2]);
        k = p_kind[idx]; a = m_reg[p_rs1[idx]]; b = m_reg[p_rs2[idx]]; iv = p_imm[idx];
        taken = 1'b0; mem_op = 1'b0;
        case (k)
            K_ADD:  res = a + b;
            K_SUB:  res = a - b;
            K_AND:  res = a & b;
            K_OR:   res = a | b;
            K_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_NOR:  res = ~(a | b);
            K_ADDI: res = a + iv;
            K_ANDI: res = a & iv;
            K_ORI:  res = a | iv;
            K_SLTI: res = ($signed(a) < $signed(iv)) ? 32'd1 : 32'd0;
            K_LW, K_SW: begin res = a + iv; mem_op = 1'b1; end
            K_BEQ:  begin res = a - b; taken = (a == b); end
            default: res = 32'd0;
        endcase
        chk("alu_result", alu_result, res);
        if (mem_op) begin
            addr = res[8:0];
            chk("dmem_addr", 32'(d_addr_seen), 32'(addr));
            chk("dmem_we", 32'(d_we_seen), (k == K_SW) ? 32'd1 : 32'd0);
            chk("dmem_req_len", 32'(d_req_cycles), 32'(d_used + 1));
            if (k == K_SW) begin
                chk("dmem_wdata", d_wdata_seen, b);
                ref_mem[addr] = b;
            end else begin
                res = ref_mem[addr];
            end
        end
        lat = 4 + i_used + (mem_op ? 1 + d_used : 0);
        if (have_last) chk("latency", 32'(cyc - last_done), 32'(lat));
        have_last = 1'b1; last_done = cyc;
        if (k != K_SW && k != K_BEQ && p_rd[idx] != 0) m_reg[p_rd[idx]] = res;
        m_pc = taken ? (m_pc + iv[7:0]) : (m_pc + 8'd4);
        n_instr++;
    endtask

    // One clock: observe at the falling edge, then drive memory responses for the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("req_excl", 32'(imem_req & dmem_req), 32'd0);
        if (instr_done) model_step();
        if (imem_req) begin
            if (!i_pend) begin
                i_pend = 1'b1; i_wait = int'($urandom_range(0, 2)); i_used = i_wait;
                chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
            end
            if (i_wait == 0) begin
                imem_ack = 1'b1; imem_rdata = prog[imem_addr[7:2]]; i_pend = 1'b0;
            end else begin
                i_wait--; imem_ack = 1'b0; imem_rdata = $urandom;
            end
        end else begin
            imem_ack = ($urandom_range(0, 3) == 0); imem_rdata = $urandom;
        end
        if (dmem_req) begin
            if (!d_pend) begin
                d_pend = 1'b1;
                d_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
                force_wait = -1; d_used = d_wait; d_req_cycles = 0;
            end
            d_req_cycles++;
            d_addr_seen = dmem_addr; d_we_seen = dmem_we; d_wdata_seen = dmem_wdata;
            if (d_wait == 0 && !(hold_st && dmem_we)) begin
                dmem_ack = 1'b1;
                if (dmem_we) ext_mem[dmem_addr] = dmem_wdata;
                dmem_rdata = dmem_we ? $urandom : ext_mem[dmem_addr];
                d_pend = 1'b0;
            end else begin
                if (d_wait > 0) d_wait--;
                dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
        end else begin
            dmem_ack = ($urandom_range(0, 3) == 0); dmem_rdata = $urandom;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = 32'd0; dmem_rdata = 32'd0;
        i_pend = 1'b0; d_pend = 1'b0; have_last = 1'b0; hold_st = 1'b0;
        m_pc = 8'd0;
        for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_instr_done", 32'(instr_done), 32'd0);
        chk("rst_alu_result", alu_result, 32'd0);
        reset = 1'b1;
        tick();
        chk("imem_req_after_release", 32'(imem_req), 32'd1);
    endtask

    initial begin
        int n, bad;
        reset = 1'b0;
        force_wait = 3;
        put(0, K_ADDI, 1, 0, 0, 5);
        put(1, K_ADD,  2, 1, 1, 0);
        put(2, K_SW,   0, 0, 1, 4);
        put(3, K_LW,   3, 0, 0, 8);
        put(4, K_ADD,  5, 3, 0, 0);
        put(5, K_BEQ,  0, 0, 0, 8);
        put_random(6);
        put(7, K_BEQ,  0, 1, 2, 8);
        put(8, K_ADDI, 0, 0, 0, 7);
        put(9, K_ADD,  4, 0, 0, 0);
        for (int j = 10; j < 64; j++) put_random(j);
        for (int j = 0; j < 512; j++) begin
            ref_mem[j] = $urandom; ext_mem[j] = ref_mem[j];
        end
        ref_mem[8] = 32'hDEADBEEF; ext_mem[8] = 32'hDEADBEEF;

        do_reset();
        repeat (3000) tick();

        // Stall a store in MEM, then reset underneath it.
        hold_st = 1'b1;
        n = 0;
        while (!(dmem_req && dmem_we) && n < 3000) begin tick(); n++; end
        chk("store_reached", 32'(dmem_req && dmem_we), 32'd1);
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
        chk("midrst_dmem_we", 32'(dmem_we), 32'd0);
        chk("midrst_imem_req", 32'(imem_req), 32'd0);
        do_reset();
        repeat (1500) tick();

        n = 0;
        do begin tick(); n++; end while (!instr_done && n < 100);
        chk("drain_done", 32'(instr_done), 32'd1);
        bad = 0;
        for (int j = 0; j < 512; j++) if (ext_mem[j] !== ref_mem[j]) bad++;
        chk("dmem_contents", 32'(bad), 32'd0);
        chk("progress", 32'(n_instr > 150), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
